// File: rtl/bcd_calc_pkg.sv
// Shared types, constants and BCD/binary helpers for the desk calculator core.
package bcd_calc_pkg;

    localparam int NDIG  = 11;
    localparam int BCD_W = 4 * NDIG;   // digit field of the accumulator
    localparam int ACC_W = BCD_W + 4;  // sign nibble + digits
    localparam int MAG_W = 37;         // enough for 99_999_999_999

    localparam logic [MAG_W-1:0] MAX_MAG = 37'd99_999_999_999;

    typedef enum logic [2:0] {
        OP_ADD  = 3'b000,
        OP_SUB  = 3'b001,
        OP_MUL  = 3'b010,
        OP_DIV  = 3'b011,
        OP_CLR  = 3'b100,
        OP_LOAD = 3'b101,
        OP_NOP  = 3'b111
    } op_t;

    localparam logic [7:0] CH_PLUS  = 8'h2B;
    localparam logic [7:0] CH_MINUS = 8'h2D;
    localparam logic [7:0] CH_STAR  = 8'h2A;
    localparam logic [7:0] CH_SLASH = 8'h2F;
    localparam logic [7:0] CH_EQ    = 8'h3D;
    localparam logic [7:0] CH_CU    = 8'h43;
    localparam logic [7:0] CH_CL    = 8'h63;
    localparam logic [7:0] CH_CR    = 8'h0D;
    localparam logic [7:0] CH_ZERO  = 8'h30;
    localparam logic [7:0] CH_NINE  = 8'h39;

    // ASCII digit to BCD; anything that is not '0'..'9' reads as zero.
    function automatic logic [3:0] char_to_digit(input logic [7:0] ch);
        logic [7:0] d;
        d = ch - CH_ZERO;
        return ((ch >= CH_ZERO) && (ch <= CH_NINE)) ? d[3:0] : 4'd0;
    endfunction

    // Packed BCD (MSD in the top nibble) to binary magnitude.
    function automatic logic [MAG_W-1:0] bcd_to_bin(input logic [BCD_W-1:0] bcd);
        logic [MAG_W-1:0] v;
        v = '0;
        for (int i = NDIG - 1; i >= 0; i--) begin
            v = v * 37'd10 + {33'd0, bcd[4*i +: 4]};
        end
        return v;
    endfunction

    // Binary magnitude to packed BCD by shift-add-3 (double dabble).
    function automatic logic [BCD_W-1:0] bin_to_bcd(input logic [MAG_W-1:0] bin);
        logic [BCD_W-1:0] bcd;
        bcd = '0;
        for (int i = MAG_W - 1; i >= 0; i--) begin
            for (int d = 0; d < NDIG; d++) begin
                bcd[4*d +: 4] = (bcd[4*d +: 4] >= 4'd5) ? bcd[4*d +: 4] + 4'd3 : bcd[4*d +: 4];
            end
            bcd = {bcd[BCD_W-2:0], bin[i]};
        end
        return bcd;
    endfunction

endpackage

// File: rtl/bcd_calc_baud_divider.sv
// Baud/oversample clock: 50 % square wave toggling every HALF system clocks.
module baud_divider #(
    parameter int CLK_HZ     = 100_000_000,
    parameter int BAUD       = 9600,
    parameter int OVERSAMPLE = 16
) (
    input  logic clk,
    input  logic rst,
    output logic baud
);

    localparam int HALF_RAW = CLK_HZ / (2 * BAUD * OVERSAMPLE);
    // A degenerate parameter set still yields a legal divider of one.
    localparam int HALF     = (HALF_RAW < 1) ? 1 : HALF_RAW;
    localparam int CW       = (HALF > 1) ? $clog2(HALF) : 1;

    logic [CW-1:0] cnt;

    // Count 0..HALF-1 and flip the output on every wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt  <= '0;
            baud <= 1'b0;
        end else if (cnt == CW'(HALF - 1)) begin
            cnt  <= '0;
            baud <= ~baud;
        end else begin
            cnt  <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/bcd_calc_core.sv
// Calculator arithmetic core: command-line decoder, signed-BCD accumulator ALU
// and the baud generator used by the surrounding UART.
module bcd_calc_core
    import bcd_calc_pkg::*;
#(
    parameter int CLK_HZ     = 100_000_000,
    parameter int BAUD       = 9600,
    parameter int OVERSAMPLE = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ena,
    input  logic [119:0] in_q,
    output logic         baud,
    output logic [47:0]  acc_out,
    output logic         overflow
);

    logic              ena_q;
    logic              fire;
    logic [ACC_W-1:0]  acc_reg;
    logic              ovf_reg;

    op_t               op;
    logic              opnd_sign;
    logic [BCD_W-1:0]  opnd_bcd;
    logic [MAG_W-1:0]  opnd_mag;
    logic [MAG_W-1:0]  acc_mag;
    logic              acc_sign;
    logic signed [38:0] acc_sv;
    logic signed [38:0] opnd_sv;
    logic signed [38:0] sum;
    logic [38:0]       sum_abs;
    logic [73:0]       res_mag;
    logic              res_sign;
    logic              div_zero;
    logic              keep_acc;
    logic [ACC_W-1:0]  next_acc;
    logic              next_ovf;

    baud_divider #(
        .CLK_HZ     (CLK_HZ),
        .BAUD       (BAUD),
        .OVERSAMPLE (OVERSAMPLE)
    ) u_baud (
        .clk  (clk),
        .rst  (rst),
        .baud (baud)
    );

    assign fire     = ena & ~ena_q;
    assign acc_out  = acc_reg;
    assign overflow = ovf_reg;

    // Decode the command line and compute the accumulator's next value.
    always_comb begin
        op        = OP_NOP;
        opnd_bcd  = '0;
        res_mag   = '0;
        res_sign  = 1'b0;
        div_zero  = 1'b0;
        keep_acc  = 1'b0;
        sum       = '0;
        next_acc  = acc_reg;
        next_ovf  = 1'b0;

        case (in_q[111:104])
            CH_PLUS:        op = OP_ADD;
            CH_MINUS:       op = OP_SUB;
            CH_STAR:        op = OP_MUL;
            CH_SLASH:       op = OP_DIV;
            CH_CU, CH_CL:   op = OP_CLR;
            CH_EQ:          op = OP_LOAD;
            default:        op = OP_NOP;
        endcase

        for (int i = 0; i < NDIG; i++) begin
            opnd_bcd[4*(NDIG-1-i) +: 4] = char_to_digit(in_q[95-8*i -: 8]);
        end
        opnd_mag  = bcd_to_bin(opnd_bcd);
        // A typed "-0" is an ordinary +0.
        opnd_sign = (in_q[103:96] == CH_MINUS) && (opnd_mag != 37'd0);

        acc_mag  = bcd_to_bin(acc_reg[BCD_W-1:0]);
        acc_sign = acc_reg[BCD_W];
        acc_sv   = acc_sign  ? -$signed({2'b00, acc_mag})  : $signed({2'b00, acc_mag});
        opnd_sv  = opnd_sign ? -$signed({2'b00, opnd_mag}) : $signed({2'b00, opnd_mag});

        case (op)
            OP_ADD: begin
                sum      = acc_sv + opnd_sv;
                res_sign = sum[38];
            end
            OP_SUB: begin
                sum      = acc_sv - opnd_sv;
                res_sign = sum[38];
            end
            OP_MUL: begin
                res_mag  = {37'd0, acc_mag} * {37'd0, opnd_mag};
                res_sign = acc_sign ^ opnd_sign;
            end
            OP_DIV: begin
                if (opnd_mag == 37'd0) begin
                    div_zero = 1'b1;
                end else begin
                    res_mag  = {37'd0, acc_mag / opnd_mag};
                    res_sign = acc_sign ^ opnd_sign;
                end
            end
            OP_LOAD: begin
                res_mag  = {37'd0, opnd_mag};
                res_sign = opnd_sign;
            end
            OP_CLR: begin
                res_mag  = '0;
                res_sign = 1'b0;
            end
            default: begin
                keep_acc = 1'b1;
            end
        endcase

        sum_abs = sum[38] ? 39'(-sum) : 39'(sum);
        if ((op == OP_ADD) || (op == OP_SUB)) begin
            res_mag = {35'd0, sum_abs};
        end else begin
            res_mag = res_mag;
        end

        if (div_zero || (res_mag > {37'd0, MAX_MAG})) begin
            next_acc = acc_reg;
            next_ovf = 1'b1;
        end else if (keep_acc) begin
            next_acc = acc_reg;
            next_ovf = 1'b0;
        end else begin
            // Zero is always stored with a positive sign.
            next_acc = {3'b000, res_sign && (res_mag != 74'd0), bin_to_bcd(res_mag[MAG_W-1:0])};
            next_ovf = 1'b0;
        end
    end

    // Edge-detect ena and commit one operation per rising edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ena_q   <= 1'b0;
            acc_reg <= '0;
            ovf_reg <= 1'b0;
        end else if (fire) begin
            ena_q   <= ena;
            acc_reg <= next_acc;
            ovf_reg <= next_ovf;
        end else begin
            ena_q   <= ena;
        end
    end

endmodule

// File: tb/tb_bcd_calc_core.sv
// Directed bench for bcd_calc_core with hand-computed expected values.
module tb_bcd_calc_core;

    logic         clk;
    logic         rst;
    logic         ena;
    logic [119:0] in_q;
    logic         baud;
    logic [47:0]  acc_out;
    logic         overflow;

    int checks;
    int failures;

    bcd_calc_core #(
        .CLK_HZ     (128),
        .BAUD       (1),
        .OVERSAMPLE (16)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .ena      (ena),
        .in_q     (in_q),
        .baud     (baud),
        .acc_out  (acc_out),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Build in_q from a 13-char "op sign 11-digits" line followed by CR.
    function automatic logic [119:0] make_line(input string s);
        logic [119:0] v;
        v = {8'h00, {13{8'h20}}, 8'h0D};
        for (int i = 0; i < 13; i++) begin
            if (i < s.len()) v[111-8*i -: 8] = s[i];
        end
        return v;
    endfunction

    // One ena pulse with the given line, then ena low for one full clock.
    task automatic fire(input string s);
        @(negedge clk);
        in_q = make_line(s);
        ena  = 1'b1;
        @(negedge clk);
        ena  = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset;
        rst  = 1'b1;
        ena  = 1'b0;
        in_q = '0;
        repeat (3) @(negedge clk);
        checks++;
        if (acc_out !== 48'h0 || overflow !== 1'b0 || baud !== 1'b0) begin
            failures++;
            $display("FAIL reset: acc=%h ovf=%b baud=%b want acc=0 ovf=0 baud=0", acc_out, overflow, baud);
        end
        rst = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            checks++;
            if (baud !== 1'(((k / 4) % 2))) begin
                failures++;
                $display("FAIL baud_k%0d: got %b want %b", k, baud, 1'(((k / 4) % 2)));
            end
        end
    endtask

    task automatic check_acc(input string name, input logic [47:0] exp_acc, input logic exp_ovf);
        checks++;
        if (acc_out !== exp_acc || overflow !== exp_ovf) begin
            failures++;
            $display("FAIL %s: acc=%h ovf=%b want acc=%h ovf=%b", name, acc_out, overflow, exp_acc, exp_ovf);
        end
    endtask

    task automatic test_load_add;
        fire("=+00000000123");
        check_acc("load123", 48'h0_00000000123, 1'b0);
        fire("+ 00000000877");
        check_acc("add877", 48'h0_00000001000, 1'b0);
    endtask

    task automatic test_sub_div_mul;
        fire("-+00000002000");
        check_acc("sub_neg", 48'h1_00000001000, 1'b0);
        fire("/+00000000007");
        check_acc("div7", 48'h1_00000000142, 1'b0);
        fire("*-00000000001");
        check_acc("mul_m1", 48'h0_00000000142, 1'b0);
        fire("+-00000000142");
        check_acc("zero_pos", 48'h0_00000000000, 1'b0);
        fire("=-00000000000");
        check_acc("minus_zero", 48'h0_00000000000, 1'b0);
        fire("=-00000000005");
        fire("+ 00000000003");
        check_acc("neg_plus", 48'h1_00000000002, 1'b0);
    endtask

    task automatic test_overflow;
        fire("=+99999999999");
        check_acc("load_max", 48'h0_99999999999, 1'b0);
        fire("*+00000000002");
        check_acc("mul_ovf", 48'h0_99999999999, 1'b1);
        fire("/+00000000000");
        check_acc("div0", 48'h0_99999999999, 1'b1);
        fire("++00000000001");
        check_acc("add_ovf", 48'h0_99999999999, 1'b1);
        fire("?+00000000000");
        check_acc("nop_clr_ovf", 48'h0_99999999999, 1'b0);
        fire("/+00000000000");
        fire("C+00000000000");
        check_acc("clr", 48'h0_00000000000, 1'b0);
        fire("-+99999999999");
        fire("c+00000000000");
        check_acc("clr_lower", 48'h0_00000000000, 1'b0);
    endtask

    task automatic test_held_ena;
        fire("=+00000000001");
        @(negedge clk);
        in_q = make_line("+ 00000000001");
        ena  = 1'b1;
        @(negedge clk);
        check_acc("held_first", 48'h0_00000000002, 1'b0);
        repeat (99) @(negedge clk);
        check_acc("held_100", 48'h0_00000000002, 1'b0);
        ena = 1'b0;
        @(negedge clk);
        ena = 1'b1;
        @(negedge clk);
        check_acc("rearm", 48'h0_00000000003, 1'b0);
        ena = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_bad_chars;
        fire("?+00000000005");
        check_acc("bad_op_nop", 48'h0_00000000003, 1'b0);
        fire("=+000 0000012");
        check_acc("space_digit", 48'h0_00000000012, 1'b0);
        fire("=+0000000x0A7");
        check_acc("junk_digits", 48'h0_00000000007, 1'b0);
    endtask

    task automatic test_reset_mid_op;
        fire("=+00000000456");
        @(negedge clk);
        in_q = make_line("*+00000000002");
        ena  = 1'b1;
        rst  = 1'b1;
        @(negedge clk);
        check_acc("rst_mid", 48'h0_00000000000, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        check_acc("ena_at_release", 48'h0_00000000000, 1'b0);
        ena = 1'b0;
        @(negedge clk);
        fire("=+00000000009");
        in_q = make_line("*+00000000002");
        @(negedge clk);
        rst = 1'b1;
        ena = 1'b1;
        #2;
        rst = 1'b0;
        @(negedge clk);
        check_acc("ena_high_release", 48'h0_00000000000, 1'b0);
        ena = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_load_add();
        test_sub_div_mul();
        test_overflow();
        test_held_ena();
        test_bad_chars();
        test_reset_mid_op();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
